staged_mac_vec: RTL
===================

Name: staged_mac_vec

Overview:
Parametrised successor to the single-lane staged MAC: NUM_LANES independent signed fixed-point MAC lanes share one AXI-Stream slave input and one master output. Supports a per-packet bias load (TUSER), a configurable fractional point, saturating or wrapping output, optional ReLU and a saturation flag. Sits between the weight/activation streamer and the layer output writer in the accelerator datapath.

Parameters:
DATA_WIDTH, 32, width of weight, activation and output words (signed two's complement)
FRAC_BITS, 16, fractional bits of the Q format (Q16.16 default)
ACCUM_BITS, 8, guard bits above the 2*DATA_WIDTH product in each accumulator
NUM_LANES, 4, parallel MAC lanes
SATURATE, 1, 1 = clamp output to signed DATA_WIDTH range; 0 = keep low DATA_WIDTH bits (wrap)

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, synchronous, active-low
SD_AXIS_TDATA  in  NUM_LANES*2*DATA_WIDTH  lane i at [i*2*DW +: 2*DW] = {weight, activation}
SD_AXIS_TVALID  in  1  input beat valid
SD_AXIS_TREADY  out  1  input beat accepted when high with TVALID
SD_AXIS_TLAST  in  1  last beat of a dot-product packet
SD_AXIS_TUSER  in  1  bias beat: load accumulator with activation, no multiply
SD_AXIS_TID  in  8  packet id
CFG_RELU  in  1  ReLU enable, sampled on the first beat of each packet
MO_AXIS_TDATA  out  NUM_LANES*DATA_WIDTH  lane i result at [i*DW +: DW]
MO_AXIS_TVALID  out  1  result valid
MO_AXIS_TREADY  in  1  downstream ready
MO_AXIS_TLAST  out  1  always 1 when TVALID (one beat per packet)
MO_AXIS_TID  out  8  TID of the packet's TLAST beat
MO_AXIS_TUSER  out  1  1 = at least one lane saturated

Behaviour:
- Reset (ARESETN low at ACLK edge): all pipeline valids, accumulators, FSM and output registers cleared. MO_AXIS_TVALID/TDATA/TLAST/TID/TUSER = 0. Partial packets are discarded. SD_AXIS_TREADY = 0 during reset.
- Global enable en = !MO_AXIS_TVALID || MO_AXIS_TREADY. SD_AXIS_TREADY = en. When en is low, all stages hold.
- Pipeline (each stage advances on en):
  - S1: register the accepted beat plus last/user/id/relu.
  - S2: per-lane signed product, 2*DW bits.
  - S3: accumulate into a 2*DW+ACCUM_BITS signed accumulator, with inputs sign-extended.
  - S4: quantise into the output register.
  - Latency: beat accepted at edge k; its result is visible after edge k+3 (TLAST beat -> MO_AXIS_TVALID).
- Packet FSM at S3:
  - IDLE: the next valid beat starts a packet. Accumulator = (TUSER ? activation<<<FRAC_BITS : product). CFG_RELU is latched. Go to ACCUM, or stay in IDLE if that beat is TLAST.
  - ACCUM: TUSER=0 beat adds product. TUSER=1 beat mid-packet replaces the accumulator with activation<<<FRAC_BITS (re-bias). TLAST beat -> IDLE and fires S4.
- Quantise per lane: r = acc >>> FRAC_BITS (arithmetic).
  - SATURATE=1: clamp to [-2^(DW-1), 2^(DW-1)-1]; the flag is set if clamped.
  - SATURATE=0: take r[DW-1:0]; the flag is set if the discarded upper bits are not a sign extension.
  - ReLU (latched) is applied after clamping: negative -> 0.
  - MO_AXIS_TUSER = OR of lane flags.
- Output holds stable while TVALID && !TREADY. A new result may load on the same edge the previous one is consumed.
- Accumulator overflow beyond the guard bits wraps silently. This is not flagged.
- A single-beat packet (TLAST on the first beat) is legal.

Decomposition:
- Package staged_mac_pkg: Q-format localparams (product/accumulator widths and slice bounds) and the fsm_e enum {IDLE, ACCUM}. Lane pack/unpack helper functions also go here.
- One sub-module mac_lane (S2 multiply, S3 accumulate, S4 quantise for one lane), instantiated NUM_LANES times by generate. The top holds the handshake, FSM and sideband pipeline.

Test Plan:
- Defaults, lane 0 weight 0x00012000, activation 0x00024000, TLAST on beat 1 -> lane 0 = 0x00028800, TUSER=0, TID echoed, TVALID exactly 3 edges after acceptance.
- Same pair 10 beats back-to-back, TLAST on beat 10, TID=9 -> 0x00195000, one output beat, TID=9.
- Bias beat (TUSER=1, activation 0x00010000), then product beat 0x00012000*0x00024000 with TLAST -> 0x00038800.
- 0x7FFF0000*0x7FFF0000 for 2 beats -> 0x7FFFFFFF with TUSER=1 (SATURATE=1). Negative case: 0x80000000*0x7FFF0000 -> 0x80000000, TUSER=1.
- Weight 0xFFFF0000, activation 0x00020000: CFG_RELU=0 -> 0xFFFE0000; CFG_RELU=1 -> 0x00000000. Lanes differ concurrently.
- Backpressure: MO_AXIS_TREADY=0 for 5 cycles with a result pending -> SD_AXIS_TREADY=0 and output stable; a second packet completes correctly after release. ARESETN low mid-packet -> next packet result excludes the pre-reset beats.

Source files
------------

// File: rtl/staged_mac_pkg.sv
// -----------------------------------------------------------------------------
// staged_mac_pkg
// Shared definitions for the multi-lane staged MAC:
//   - default Q-format / geometry values used as module parameter defaults
//   - width helpers for the product and accumulator
//   - lane pack/unpack offset helpers for the flat AXI-Stream data buses
//   - fsm_e, the packet-tracking state machine encoding
// No ports (package).
// -----------------------------------------------------------------------------
package staged_mac_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_FRAC_BITS  = 16;
   localparam int DEF_ACCUM_BITS = 8;
   localparam int DEF_NUM_LANES  = 4;
   localparam int TID_W          = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } fsm_e;

   // Full-precision signed product of two data words.
   function automatic int prod_width(input int dw);
      return 2 * dw;
   endfunction

   // Accumulator: product width plus guard bits.
   function automatic int acc_width(input int dw, input int guard);
      return 2 * dw + guard;
   endfunction

   // LSB of lane's {weight, activation} pair on the input bus.
   // The activation occupies the low half, the weight the high half.
   function automatic int in_lane_lsb(input int lane, input int dw);
      return lane * 2 * dw;
   endfunction

   // LSB of lane's result word on the output bus.
   function automatic int out_lane_lsb(input int lane, input int dw);
      return lane * dw;
   endfunction

endpackage

// File: rtl/mac_lane.sv
// -----------------------------------------------------------------------------
// mac_lane
// One signed fixed-point MAC lane: S2 multiply, S3 accumulate, S4 quantise.
// All sequencing (handshake, packet FSM, sideband) lives in the top; this lane
// only reacts to the per-stage strobes it is given.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   en           global pipeline advance
//   s1_valid     S1 holds a beat: register product and activation
//   s1_weight    S1 weight word (signed)
//   s1_act       S1 activation word (signed)
//   s2_valid     S2 holds a beat: update accumulator
//   s2_start     the S2 beat is the first of a packet (overwrite, not add)
//   s2_bias      the S2 beat is a bias beat (load activation<<<FRAC_BITS)
//   s3_fire      packet complete at S3: load quantised result
//   s3_relu      ReLU setting latched for the completing packet
//   q            quantised lane result (S4 output register)
//   sat_flag     result was clamped (SATURATE=1) or wrapped (SATURATE=0)
// -----------------------------------------------------------------------------
module mac_lane
   import staged_mac_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FRAC_BITS  = DEF_FRAC_BITS,
   parameter int ACCUM_BITS = DEF_ACCUM_BITS,
   parameter bit SATURATE   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  s1_valid,
   input  logic [DATA_WIDTH-1:0] s1_weight,
   input  logic [DATA_WIDTH-1:0] s1_act,
   input  logic                  s2_valid,
   input  logic                  s2_start,
   input  logic                  s2_bias,
   input  logic                  s3_fire,
   input  logic                  s3_relu,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  sat_flag
);

   localparam int DW = DATA_WIDTH;
   localparam int PW = prod_width(DATA_WIDTH);
   localparam int AW = acc_width(DATA_WIDTH, ACCUM_BITS);

   logic signed [PW-1:0] prod_c;
   logic signed [PW-1:0] prod_r;
   logic        [DW-1:0] act_r;
   logic signed [AW-1:0] acc_r;
   logic signed [AW-1:0] acc_next;
   logic signed [AW-1:0] prod_ext;
   logic signed [AW-1:0] act_ext;
   logic signed [AW-1:0] bias_ext;
   logic signed [AW-1:0] shifted;
   logic                 in_range;
   logic        [DW-1:0] q_next;
   logic                 flag_next;

   // Operands are sign-extended to the product width so the multiply is a
   // plain full-width signed product.
   assign prod_c = $signed({{DW{s1_weight[DW-1]}}, s1_weight}) *
                   $signed({{DW{s1_act[DW-1]}}, s1_act});

   assign prod_ext = {{ACCUM_BITS{prod_r[PW-1]}}, prod_r};
   assign act_ext  = {{(AW-DW){act_r[DW-1]}}, act_r};
   assign bias_ext = act_ext <<< FRAC_BITS;

   // Bias beats replace the accumulator at any point in the packet; the
   // first product beat of a packet overwrites whatever the previous packet
   // left behind. Overflow past the guard bits wraps.
   always_comb begin
      acc_next = acc_r + prod_ext;
      if (s2_bias) begin
         acc_next = bias_ext;
      end else if (s2_start) begin
         acc_next = prod_ext;
      end
   end

   // The result fits in DW bits exactly when everything from bit DW-1 upward
   // is a copy of the sign; the same test drives the flag in both modes.
   always_comb begin
      shifted   = acc_r >>> FRAC_BITS;
      in_range  = (shifted[AW-1:DW-1] == {(AW-DW+1){shifted[DW-1]}});
      q_next    = shifted[DW-1:0];
      flag_next = !in_range;
      if (SATURATE && !in_range) begin
         q_next = shifted[AW-1] ? {1'b1, {(DW-1){1'b0}}}
                                : {1'b0, {(DW-1){1'b1}}};
      end
      if (s3_relu && q_next[DW-1]) begin
         q_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prod_r   <= '0;
         act_r    <= '0;
         acc_r    <= '0;
         q        <= '0;
         sat_flag <= 1'b0;
      end else if (en) begin
         if (s1_valid) begin
            prod_r <= prod_c;
            act_r  <= s1_act;
         end
         if (s2_valid) begin
            acc_r <= acc_next;
         end
         if (s3_fire) begin
            q        <= q_next;
            sat_flag <= flag_next;
         end
      end
   end

endmodule

// File: rtl/staged_mac_vec.sv
// -----------------------------------------------------------------------------
// staged_mac_vec
// NUM_LANES independent signed fixed-point MAC lanes behind one AXI-Stream
// slave and one AXI-Stream master. Each packet of beats produces one output
// beat carrying every lane's quantised dot product.
//
// Ports:
//   ACLK, ARESETN    clock, synchronous active-low reset
//   SD_AXIS_TDATA    lane i {weight, activation} at [i*2*DW +: 2*DW]
//   SD_AXIS_TVALID   input beat valid
//   SD_AXIS_TREADY   input beat accepted when high together with TVALID
//   SD_AXIS_TLAST    last beat of a packet
//   SD_AXIS_TUSER    bias beat (accumulator <= activation<<<FRAC_BITS)
//   SD_AXIS_TID      packet id
//   CFG_RELU         ReLU enable, taken from the first beat of each packet
//   MO_AXIS_TDATA    lane i result at [i*DW +: DW]
//   MO_AXIS_TVALID   result valid
//   MO_AXIS_TREADY   downstream ready
//   MO_AXIS_TLAST    1 with every result (one beat per packet)
//   MO_AXIS_TID      TID of the packet's TLAST beat
//   MO_AXIS_TUSER    at least one lane saturated / wrapped
//   dbg_state        packet FSM state (observability)
//
// Handshake: a beat transfers on a rising ACLK edge where VALID and READY are
// both high. The whole pipeline advances on en = !MO_AXIS_TVALID ||
// MO_AXIS_TREADY, and SD_AXIS_TREADY is en (forced low while ARESETN is low),
// so a stalled output freezes every stage and the input; a pending result
// may be replaced on the same edge it is consumed.
//
// Pipeline: S1 input register -> S2 product -> S3 accumulate + FSM -> S4
// output register. A TLAST beat accepted at edge k is presented after k+3.
// -----------------------------------------------------------------------------
module staged_mac_vec
   import staged_mac_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FRAC_BITS  = DEF_FRAC_BITS,
   parameter int ACCUM_BITS = DEF_ACCUM_BITS,
   parameter int NUM_LANES  = DEF_NUM_LANES,
   parameter bit SATURATE   = 1'b1
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic [NUM_LANES*2*DATA_WIDTH-1:0] SD_AXIS_TDATA,
   input  logic                              SD_AXIS_TVALID,
   output logic                              SD_AXIS_TREADY,
   input  logic                              SD_AXIS_TLAST,
   input  logic                              SD_AXIS_TUSER,
   input  logic [TID_W-1:0]                  SD_AXIS_TID,
   input  logic                              CFG_RELU,
   output logic [NUM_LANES*DATA_WIDTH-1:0]   MO_AXIS_TDATA,
   output logic                              MO_AXIS_TVALID,
   input  logic                              MO_AXIS_TREADY,
   output logic                              MO_AXIS_TLAST,
   output logic [TID_W-1:0]                  MO_AXIS_TID,
   output logic                              MO_AXIS_TUSER,
   output fsm_e                              dbg_state
);

   localparam int DW   = DATA_WIDTH;
   localparam int IN_W = NUM_LANES * 2 * DATA_WIDTH;

   logic en;
   logic accept;

   // S1: accepted beat
   logic             s1_valid;
   logic [IN_W-1:0]  s1_data;
   logic             s1_last;
   logic             s1_user;
   logic             s1_relu;
   logic [TID_W-1:0] s1_id;

   // S2: sideband travelling alongside the lane products
   logic             s2_valid;
   logic             s2_last;
   logic             s2_user;
   logic             s2_relu;
   logic [TID_W-1:0] s2_id;

   // S3: packet tracking
   fsm_e             state;
   fsm_e             state_next;
   logic             pkt_start;
   logic             pkt_relu;
   logic             relu_eff;
   logic             s3_fire;
   logic             s3_relu;
   logic [TID_W-1:0] s3_id;

   // S4: output sideband
   logic             mo_valid;
   logic             mo_last;
   logic [TID_W-1:0] mo_id;
   logic [NUM_LANES-1:0] lane_flag;

   assign en             = !mo_valid || MO_AXIS_TREADY;
   assign SD_AXIS_TREADY = en && ARESETN;
   assign accept         = SD_AXIS_TVALID && SD_AXIS_TREADY;

   assign MO_AXIS_TVALID = mo_valid;
   assign MO_AXIS_TLAST  = mo_last;
   assign MO_AXIS_TID    = mo_id;
   assign MO_AXIS_TUSER  = |lane_flag;
   assign dbg_state      = state;

   // ---------------------------------------------------------------------------
   // Packet FSM: the beat currently in S2 is the one being accumulated.
   // ---------------------------------------------------------------------------
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      pkt_start  = (state == IDLE);
      // ReLU comes from the packet's first beat; later beats reuse the latch.
      relu_eff   = (state == IDLE) ? s2_relu : pkt_relu;
      if (en && s2_valid) begin
         state_next = s2_last ? IDLE : ACCUM;
      end
   end

   // ---------------------------------------------------------------------------
   // Sideband pipeline
   // ---------------------------------------------------------------------------
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_last  <= 1'b0;
         s1_user  <= 1'b0;
         s1_relu  <= 1'b0;
         s1_id    <= '0;
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s2_user  <= 1'b0;
         s2_relu  <= 1'b0;
         s2_id    <= '0;
         pkt_relu <= 1'b0;
         s3_fire  <= 1'b0;
         s3_relu  <= 1'b0;
         s3_id    <= '0;
         mo_valid <= 1'b0;
         mo_last  <= 1'b0;
         mo_id    <= '0;
      end else if (en) begin
         s1_valid <= accept;
         if (accept) begin
            s1_data <= SD_AXIS_TDATA;
            s1_last <= SD_AXIS_TLAST;
            s1_user <= SD_AXIS_TUSER;
            s1_relu <= CFG_RELU;
            s1_id   <= SD_AXIS_TID;
         end

         s2_valid <= s1_valid;
         s2_last  <= s1_last;
         s2_user  <= s1_user;
         s2_relu  <= s1_relu;
         s2_id    <= s1_id;

         s3_fire <= s2_valid && s2_last;
         if (s2_valid) begin
            pkt_relu <= relu_eff;
            s3_relu  <= relu_eff;
            s3_id    <= s2_id;
         end

         mo_valid <= s3_fire;
         mo_last  <= s3_fire;
         if (s3_fire) begin
            mo_id <= s3_id;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Lanes
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam int ILSB = in_lane_lsb(i, DATA_WIDTH);
      localparam int OLSB = out_lane_lsb(i, DATA_WIDTH);

      mac_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .FRAC_BITS  (FRAC_BITS),
         .ACCUM_BITS (ACCUM_BITS),
         .SATURATE   (SATURATE)
      ) u_lane (
         .clk       (ACLK),
         .rst_n     (ARESETN),
         .en        (en),
         .s1_valid  (s1_valid),
         .s1_weight (s1_data[ILSB+DW +: DW]),
         .s1_act    (s1_data[ILSB +: DW]),
         .s2_valid  (s2_valid),
         .s2_start  (pkt_start),
         .s2_bias   (s2_user),
         .s3_fire   (s3_fire),
         .s3_relu   (s3_relu),
         .q         (MO_AXIS_TDATA[OLSB +: DW]),
         .sat_flag  (lane_flag[i])
      );
   end

endmodule
